// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache sitting between the
// MEM-stage load/store path and a byte-addressed data memory (async read, sync write).
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_re,
    input  logic                  cpu_we,
    input  logic [2:0]            cpu_funct3,
    input  logic [DATA_WIDTH-1:0] cpu_wd,
    output logic [DATA_WIDTH-1:0] cpu_rd,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [2:0]            mem_funct3,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - 4 - IDX_W;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [31:0]       hit_q, hit_d;
    logic [31:0]       miss_q, miss_d;

    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [31:0]       data_q [SETS][4];

    logic [3:0]        off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              funct_ok;
    logic              aligned;
    logic              cacheable;
    logic              hit;
    logic [31:0]       hit_word;
    logic [4:0]        byte_sh;
    logic [31:0]       store_word;
    logic              store_we;
    logic              refill_we;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3);
        case (f3)
            3'b000:  extend = {{24{w[7]}}, w[7:0]};
            3'b001:  extend = {{16{w[15]}}, w[15:0]};
            3'b010:  extend = w;
            3'b100:  extend = {24'd0, w[7:0]};
            3'b101:  extend = {16'd0, w[15:0]};
            default: extend = 32'd0;
        endcase
    endfunction

    assign off      = cpu_addr[3:0];
    assign idx      = cpu_addr[4 +: IDX_W];
    assign tag      = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign hit_word = data_q[idx][off[3:2]];
    assign byte_sh  = {off[1:0], 3'b000};
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        funct_ok = (cpu_funct3 == 3'b000) || (cpu_funct3 == 3'b001) || (cpu_funct3 == 3'b010) ||
                   (cpu_funct3 == 3'b100) || (cpu_funct3 == 3'b101);
        case (cpu_funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~cpu_addr[0];
            2'b10:   aligned = (cpu_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        cacheable = (cpu_addr[ADDR_WIDTH-1:17] == '0) && aligned && funct_ok;
    end

    // Merge the store lanes into the resident word so a store hit keeps the line coherent.
    always_comb begin
        store_word = hit_word;
        case (cpu_funct3[1:0])
            2'b00:   store_word[byte_sh +: 8]             = cpu_wd[7:0];
            2'b01:   store_word[{off[1], 4'b0000} +: 16]  = cpu_wd[15:0];
            2'b10:   store_word                           = cpu_wd;
            default: store_word                           = hit_word;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        valid_d    = valid_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        mem_addr   = cpu_addr;
        mem_funct3 = cpu_funct3;
        mem_wd     = cpu_wd;
        mem_we     = 1'b0;
        stall      = 1'b0;
        cpu_rd     = '0;
        store_we   = 1'b0;
        refill_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_we) begin
                    mem_we   = 1'b1;
                    store_we = cacheable && hit;
                end else if (cpu_re && funct_ok) begin
                    if (!cacheable) begin
                        cpu_rd = mem_rd;
                    end else if (hit) begin
                        cpu_rd = extend(hit_word >> byte_sh, cpu_funct3);
                        hit_d  = hit_q + 32'd1;
                    end else begin
                        stall   = 1'b1;
                        miss_d  = miss_q + 32'd1;
                        state_d = REFILL;
                        beat_d  = 2'd0;
                    end
                end
            end
            REFILL: begin
                stall      = 1'b1;
                mem_funct3 = 3'b010;
                mem_addr   = {cpu_addr[ADDR_WIDTH-1:4], beat_q, 2'b00};
                refill_we  = 1'b1;
                beat_d     = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    valid_d[idx] = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rst_n) begin
            stall     = 1'b0;
            mem_we    = 1'b0;
            cpu_rd    = '0;
            store_we  = 1'b0;
            refill_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            valid_q <= '0;
            hit_q   <= 32'd0;
            miss_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone decide residency.
    always_ff @(posedge clk) begin
        if (store_we) begin
            data_q[idx][off[3:2]] <= store_word;
        end
        if (refill_we) begin
            data_q[idx][beat_q] <= mem_rd;
            if (beat_q == 2'd3) begin
                tag_q[idx] <= tag;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a byte-addressed memory model.
module tb_data_cache;

    localparam int MEM_BYTES = 1 << 19;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic        cpu_re;
    logic        cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        stall;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic        preload;
    logic [7:0]  mem [0:MEM_BYTES-1];
    logic [31:0] pw;
    logic [18:0] pa;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SETS(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_funct3 (cpu_funct3),
        .cpu_wd     (cpu_wd),
        .cpu_rd     (cpu_rd),
        .stall      (stall),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_funct3 (mem_funct3),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Memory model: default word at address a is 0xA0000000 | a, with a few overrides.
    always @(posedge clk) begin
        if (preload) begin
            for (int w = 0; w < 1024; w++) begin
                pa = 19'(32'h10000 + w * 4);
                pw = 32'hA000_0000 | (32'h10000 + w * 4);
                mem[pa]         <= pw[7:0];
                mem[pa + 19'd1] <= pw[15:8];
                mem[pa + 19'd2] <= pw[23:16];
                mem[pa + 19'd3] <= pw[31:24];
            end
            mem[19'h10000] <= 8'hEF;
            mem[19'h10001] <= 8'hBE;
            mem[19'h10002] <= 8'hAD;
            mem[19'h10003] <= 8'hDE;
            mem[19'h40000] <= 8'h00;
            mem[19'h40001] <= 8'h00;
            mem[19'h40002] <= 8'h04;
            mem[19'h40003] <= 8'hA0;
        end else if (mem_we) begin
            case (mem_funct3[1:0])
                2'b00: mem[mem_addr[18:0]] <= mem_wd[7:0];
                2'b01: begin
                    mem[mem_addr[18:0]]         <= mem_wd[7:0];
                    mem[mem_addr[18:0] + 19'd1] <= mem_wd[15:8];
                end
                2'b10: begin
                    mem[mem_addr[18:0]]         <= mem_wd[7:0];
                    mem[mem_addr[18:0] + 19'd1] <= mem_wd[15:8];
                    mem[mem_addr[18:0] + 19'd2] <= mem_wd[23:16];
                    mem[mem_addr[18:0] + 19'd3] <= mem_wd[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[mem_addr[18:0]];
        b1 = mem[mem_addr[18:0] + 19'd1];
        b2 = mem[mem_addr[18:0] + 19'd2];
        b3 = mem[mem_addr[18:0] + 19'd3];
        case (mem_funct3)
            3'b000:  mem_rd = {{24{b0[7]}}, b0};
            3'b001:  mem_rd = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_rd = {b3, b2, b1, b0};
            3'b100:  mem_rd = {24'd0, b0};
            3'b101:  mem_rd = {16'd0, b1, b0};
            default: mem_rd = 32'd0;
        endcase
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic re, input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd);
        cpu_re     = re;
        cpu_we     = we;
        cpu_funct3 = f3;
        cpu_addr   = addr;
        cpu_wd     = wd;
        #1;
    endtask

    // Full miss: request cycle plus four refill beats stall, data appears in the sixth cycle.
    task automatic do_miss(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] exp_data);
        apply_stimulus(1'b1, 1'b0, f3, addr, 32'd0);
        check_output({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
        for (int b = 0; b < 4; b++) begin
            tick();
            check_output({tag, "_stall_beat"}, {31'd0, stall}, 32'd1);
            check_output({tag, "_mem_addr"}, mem_addr, {addr[31:4], 4'(b * 4)});
            check_output({tag, "_mem_f3"}, {29'd0, mem_funct3}, 32'd2);
            check_output({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
            check_output({tag, "_rd_refill"}, cpu_rd, 32'd0);
        end
        tick();
        check_output({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        check_output({tag, "_data"}, cpu_rd, exp_data);
    endtask

    initial begin
        rst_n   = 1'b0;
        preload = 1'b1;
        apply_stimulus(1'b1, 1'b1, 3'b010, 32'h10000, 32'h5555_5555);
        tick();
        preload = 1'b0;
        tick();
        check_output("rst_stall", {31'd0, stall}, 32'd0);
        check_output("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_output("rst_cpu_rd", cpu_rd, 32'd0);
        tick();
        rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        check_output("rst_hits", hit_count, 32'd0);
        check_output("rst_misses", miss_count, 32'd0);
        check_output("idle_cpu_rd", cpu_rd, 32'd0);

        $display("[TB] cold miss on lw 0x10000");
        tick();
        do_miss("t1", 32'h10000, 3'b010, 32'hDEADBEEF);
        check_output("t1_misses", miss_count, 32'd1);
        check_output("t1_hits_pre", hit_count, 32'd0);

        $display("[TB] byte and half hits");
        tick();
        apply_stimulus(1'b1, 1'b0, 3'b000, 32'h10003, 32'd0);
        check_output("t2_lb", cpu_rd, 32'hFFFF_FFDE);
        check_output("t2_lb_stall", {31'd0, stall}, 32'd0);
        tick();
        apply_stimulus(1'b1, 1'b0, 3'b100, 32'h10003, 32'd0);
        check_output("t2_lbu", cpu_rd, 32'h0000_00DE);
        tick();
        apply_stimulus(1'b1, 1'b0, 3'b001, 32'h10002, 32'd0);
        check_output("t2_lh", cpu_rd, 32'hFFFF_DEAD);
        tick();
        apply_stimulus(1'b0, 1'b0, 3'b010, 32'h10000, 32'd0);
        check_output("t2_hits", hit_count, 32'd4);
        check_output("t2_no_load_rd", cpu_rd, 32'd0);

        $display("[TB] write-through stores");
        tick();
        apply_stimulus(1'b0, 1'b1, 3'b010, 32'h10004, 32'h1234_5678);
        check_output("t3_sw_we", {31'd0, mem_we}, 32'd1);
        check_output("t3_sw_addr", mem_addr, 32'h10004);
        check_output("t3_sw_wd", mem_wd, 32'h1234_5678);
        check_output("t3_sw_stall", {31'd0, stall}, 32'd0);
        tick();
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h10004, 32'd0);
        check_output("t3_lw_hit", cpu_rd, 32'h1234_5678);
        check_output("t3_lw_stall", {31'd0, stall}, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b1, 3'b001, 32'h10100, 32'h0000_C3D4);
        check_output("t3_sh_we", {31'd0, mem_we}, 32'd1);
        check_output("t3_sh_f3", {29'd0, mem_funct3}, 32'd1);
        tick();
        do_miss("t3_lh", 32'h10100, 3'b001, 32'hFFFF_C3D4);
        check_output("t3_misses", miss_count, 32'd2);

        $display("[TB] conflict eviction");
        tick();
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h10000, 32'd0);
        check_output("t4_hit0", cpu_rd, 32'hDEADBEEF);
        check_output("t4_hit0_stall", {31'd0, stall}, 32'd0);
        tick();
        do_miss("t4_evict", 32'h10400, 3'b010, 32'hA001_0400);
        tick();
        do_miss("t4_back", 32'h10000, 3'b010, 32'hDEADBEEF);
        tick();
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h10004, 32'd0);
        check_output("t4_wt_data", cpu_rd, 32'h1234_5678);
        tick();
        apply_stimulus(1'b0, 1'b0, 3'b010, 32'h10000, 32'd0);
        check_output("t4_misses", miss_count, 32'd4);
        check_output("t4_hits", hit_count, 32'd10);

        $display("[TB] bypass and invalid funct3");
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h10002, 32'd0);
        check_output("t5_misaligned", cpu_rd, 32'h5678_DEAD);
        check_output("t5_mis_stall", {31'd0, stall}, 32'd0);
        tick();
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h40000, 32'd0);
        check_output("t5_uncached", cpu_rd, 32'hA004_0000);
        check_output("t5_unc_stall", {31'd0, stall}, 32'd0);
        tick();
        apply_stimulus(1'b1, 1'b0, 3'b011, 32'h10000, 32'd0);
        check_output("t5_bad_f3_rd", cpu_rd, 32'd0);
        check_output("t5_bad_f3_stall", {31'd0, stall}, 32'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 3'b010, 32'h10000, 32'd0);
        check_output("t5_hits", hit_count, 32'd10);
        check_output("t5_misses", miss_count, 32'd4);

        $display("[TB] reset during refill");
        tick();
        apply_stimulus(1'b1, 1'b0, 3'b010, 32'h10400, 32'd0);
        check_output("t6_stall_req", {31'd0, stall}, 32'd1);
        tick();
        tick();
        tick();
        check_output("t6_beat2_addr", mem_addr, 32'h10408);
        rst_n = 1'b0;
        #1;
        check_output("t6_rst_stall", {31'd0, stall}, 32'd0);
        check_output("t6_rst_rd", cpu_rd, 32'd0);
        check_output("t6_rst_we", {31'd0, mem_we}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check_output("t6_hits_clr", hit_count, 32'd0);
        check_output("t6_misses_clr", miss_count, 32'd0);
        do_miss("t6_retry", 32'h10400, 3'b010, 32'hA001_0400);
        tick();
        apply_stimulus(1'b0, 1'b0, 3'b010, 32'h10000, 32'd0);
        check_output("t6_hits", hit_count, 32'd1);
        check_output("t6_misses", miss_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
